// File: rtl/uart_tx_core_if.sv
// Host-side parallel interface of the UART transmitter: word, request strobe,
// per-frame parity options and the busy indication back to the host.
interface uart_tx_core_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_core_if.slave  bus,
  output logic           tx_out
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop2_q, stop2_d;
`endif

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  // Next state; tx/busy are derived from the next state so they stay registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif
    bit_end   = (cnt_q == CNT_W'(PRESCALE - 1));

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (bus.data_valid) begin
          data_d    = bus.p_data;
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = (^data_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign tx_out   = tx_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed self-checking bench for uart_tx_core with default parameters.
module tb_uart_tx_core;

  logic clk;
  logic rst;
  logic tx_out;

  uart_tx_core_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_core #(.DATA_WIDTH(8), .PRESCALE(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tx_out (tx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_pass;
  logic tx_s   [0:255];
  logic bsy_s  [0:255];
  int   n_busy;

  // Sends one word and records tx/busy on every falling edge until busy drops.
  // inj >= 0 pulses data_valid with 0x3C at that sample index.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt, input int inj);
    bus.p_data  = d;
    bus.par_en  = pe;
    bus.par_typ = pt;
    @(posedge clk); #1 bus.data_valid = 1'b1;
    @(posedge clk); #1 bus.data_valid = 1'b0;
    bus.p_data  = ~d;
    bus.par_en  = ~pe;
    bus.par_typ = ~pt;
    n_busy = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      tx_s[i]  = tx_out;
      bsy_s[i] = bus.busy;
      if (bus.busy) n_busy++;
      if (i == inj) begin
        bus.data_valid = 1'b1;
        bus.p_data     = 8'h3C;
      end
      if (i == inj + 1) bus.data_valid = 1'b0;
      if (!bus.busy) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.data_valid = 1'b1;
    bus.p_data = 8'h5A;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx_out); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    bus.data_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL idle_after_reset: got tx=%b busy=%b want tx=1 busy=0", tx_out, bus.busy);
    else n_pass++;
  endtask

  task automatic test_parity(input logic pt, input logic par_bit);
    logic [10:0] exp;
    int bad;
    exp = {1'b1, par_bit, 8'hA5, 1'b0};
    run_frame(8'hA5, 1'b1, pt, -1);
    bad = -1;
    for (int i = 0; i < 88; i++) if (bad < 0 && tx_s[i] !== exp[i/8]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL parity%0d_seq: sample %0d got %b want %b", pt, bad, tx_s[bad], exp[bad/8]);
    else n_pass++;
    n_checks++;
    if (n_busy !== 88) $display("FAIL parity%0d_busy_len: got %0d want 88", pt, n_busy); else n_pass++;
  endtask

  task automatic test_no_parity_zero();
    int bad;
    run_frame(8'h00, 1'b0, 1'b0, -1);
    bad = -1;
    for (int i = 0; i < 80; i++) if (bad < 0 && tx_s[i] !== (i >= 72)) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL zero_seq: sample %0d got %b want %b", bad, tx_s[bad], (bad >= 72));
    else n_pass++;
    n_checks++;
    if (n_busy !== 80) $display("FAIL zero_busy_len: got %0d want 80", n_busy); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    logic [9:0] exp;
    int bad;
    exp = {1'b1, 8'hFF, 1'b0};
    run_frame(8'hFF, 1'b0, 1'b0, 20);
    bad = -1;
    for (int i = 0; i < 80; i++) if (bad < 0 && tx_s[i] !== exp[i/8]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL ignore_seq: sample %0d got %b want %b", bad, tx_s[bad], exp[bad/8]);
    else n_pass++;
    n_checks++;
    if (n_busy !== 80) $display("FAIL ignore_busy_len: got %0d want 80", n_busy); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ignore_no_second_frame: %0d active cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1, exp2;
    int bad;
    exp1 = {1'b1, 8'h55, 1'b0};
    exp2 = {1'b1, 8'hAA, 1'b0};
    bus.p_data = 8'h55;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    @(posedge clk); #1 bus.data_valid = 1'b1;
    @(posedge clk); #1 bus.p_data = 8'hAA;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      tx_s[i]  = tx_out;
      bsy_s[i] = bus.busy;
      if (i == 85) bus.data_valid = 1'b0;
    end
    bad = -1;
    for (int i = 0; i < 80; i++) if (bad < 0 && tx_s[i] !== exp1[i/8]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL b2b_frame1: sample %0d got %b want %b", bad, tx_s[bad], exp1[bad/8]);
    else n_pass++;
    bad = 0;
    for (int i = 72; i <= 80; i++) if (tx_s[i] !== 1'b1) bad++;
    n_checks++;
    if (tx_s[71] !== 1'b0 || bad != 0 || tx_s[81] !== 1'b0)
      $display("FAIL b2b_gap: s71=%b s81=%b low_in_gap=%0d want 0,0,0", tx_s[71], tx_s[81], bad);
    else n_pass++;
    n_checks++;
    if (bsy_s[80] !== 1'b0 || bsy_s[81] !== 1'b1)
      $display("FAIL b2b_busy_gap: got %b%b want 01", bsy_s[80], bsy_s[81]);
    else n_pass++;
    bad = -1;
    for (int i = 0; i < 80; i++) if (bad < 0 && tx_s[81+i] !== exp2[i/8]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL b2b_frame2: sample %0d got %b want %b", bad, tx_s[81+bad], exp2[bad/8]);
    else n_pass++;
    n_checks++;
    if (bsy_s[161] !== 1'b0 || tx_s[165] !== 1'b1)
      $display("FAIL b2b_end_idle: busy=%b tx=%b want busy=0 tx=1", bsy_s[161], tx_s[165]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    int bad;
    bus.p_data = 8'h00;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    @(posedge clk); #1 bus.data_valid = 1'b1;
    @(posedge clk); #1 bus.data_valid = 1'b0;
    for (int i = 0; i < 36; i++) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL midframe_pre: got tx=%b busy=%b want tx=0 busy=1", tx_out, bus.busy);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL midframe_async: got tx=%b busy=%b want tx=1 busy=0", tx_out, bus.busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL midframe_no_resume: got tx=%b busy=%b want tx=1 busy=0", tx_out, bus.busy);
    else n_pass++;
    exp = {1'b1, 1'b0, 8'h81, 1'b0};
    run_frame(8'h81, 1'b1, 1'b0, -1);
    bad = -1;
    for (int i = 0; i < 88; i++) if (bad < 0 && tx_s[i] !== exp[i/8]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL after_reset_seq: sample %0d got %b want %b", bad, tx_s[bad], exp[bad/8]);
    else n_pass++;
    n_checks++;
    if (n_busy !== 88) $display("FAIL after_reset_busy_len: got %0d want 88", n_busy); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.data_valid = 1'b0;
    bus.p_data = 8'h00;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    test_reset();
    test_parity(1'b0, 1'b0);
    test_parity(1'b1, 1'b1);
    test_no_parity_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
UART serial transmitter: the transmit end of the UART link whose receiver samples at PRESCALE clocks per bit.
- Accepts a parallel word with a valid strobe and serialises it LSB first as: start bit (0), DATA_WIDTH data bits, optional parity bit, stop bit (1).
- Sits between the host-side parallel interface and the serial line driving the receiver's rx_in.
- Contains the frame FSM, bit-period prescale counter, bit counter and parity generator.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).
- PRESCALE, 8, clock cycles per serial bit (legal range 2..32); must match the receiver oversampling ratio.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- p_data  input  DATA_WIDTH  parallel word to transmit
- data_valid  input  1  request strobe; p_data is accepted when data_valid=1 and busy=0
- par_en  input  1  1 = frame carries a parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- tx_out  output  1  serial line, registered, idles high
- busy  output  1  registered; high while a frame is in progress

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - tx_out=1, busy=0, state=IDLE.
  - Prescale counter, bit counter and data/parity latches are cleared.
  - A partial frame is abandoned; there is no completion.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If data_valid=1 at a clock edge, latch p_data, par_en and par_typ; next state START.
  - At that same edge tx_out goes to 0 and busy goes to 1 (one-clock latency from the accepting edge).
- Bit period:
  - Every non-IDLE state holds tx_out for exactly PRESCALE cycles.
  - The prescale counter runs 0..PRESCALE-1; the state advances when the counter equals PRESCALE-1, and the counter wraps to 0.
- START: after one bit period, go to DATA with bit counter=0.
- DATA:
  - tx_out = latched data[bit counter].
  - The bit counter increments at each bit-period end.
  - After bit DATA_WIDTH-1, go to PARITY if the latched par_en=1, else STOP.
- PARITY: tx_out = ^data when par_typ=0 (even), ~^data when par_typ=1 (odd).
- STOP: tx_out=1 for one bit period, then go to IDLE; busy falls at the same edge.
- Frame length, accepting edge to busy falling: PRESCALE*(DATA_WIDTH+2+par_en) cycles.
- data_valid while busy=1: ignored; no buffering, no error.
- p_data, par_en and par_typ changes during a frame have no effect on that frame (latched copies are used).
- Back-to-back: data_valid held high re-accepts on the first IDLE cycle, so the line stays high PRESCALE+1 cycles between frames.
- Registered outputs only; tx_out must be glitch-free.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined:
  - STOP lasts 2*PRESCALE cycles (two stop bits).
  - Frame length becomes PRESCALE*(DATA_WIDTH+3+par_en).
- Undefined: single stop bit as above; no extra logic is instantiated.

Test Plan:
1. Defaults, par_en=1, par_typ=0, p_data=0xA5, one-cycle data_valid:
   - tx_out sequence per 8-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
   - busy high exactly 88 cycles.
2. Same as 1 with par_typ=1: parity bit=1; all other bits identical.
3. par_en=0, p_data=0x00:
   - tx_out=0 for 72 cycles, then 1 for 8 cycles.
   - busy high 80 cycles.
4. data_valid pulsed with p_data=0x3C at cycle 20 of a frame carrying 0xFF: 0x3C never appears on tx_out; the 0xFF frame is unaltered.
5. data_valid held high with alternating 0x55/0xAA, par_en=0:
   - Two frames back-to-back.
   - Line high exactly 9 cycles between the last data bit and the next start bit.
6. rst asserted during the data bit 3 period:
   - tx_out=1 and busy=0 immediately, without waiting for a clock.
   - After release, a new 0x81 frame transmits correctly.
